// File: rtl/dual_fifo.sv
// Two cascaded synchronous FIFOs: a slave AXI-Stream stage feeding a show-ahead master stage.
// Define DUAL_FIFO_TLAST_EN to store and forward tlast alongside the data.
module dual_fifo #(
    parameter int data_width = 16,
    parameter int size       = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_in0,
    input  logic                  tvalid_in0,
    input  logic                  tlast_in0,
    output logic                  tready_out0,
    output logic [data_width-1:0] data_out0,
    output logic [data_width-1:0] data_out1,
    output logic                  tvalid_out1,
    output logic                  tlast_out1,
    input  logic                  tready_in1
);

    localparam int aw = $clog2(size);
`ifdef DUAL_FIFO_TLAST_EN
    localparam int ew = data_width + 1;
`else
    localparam int ew = data_width;
`endif
    localparam logic [aw:0]   depth   = size[aw:0];
    localparam logic [aw-1:0] ptr_one = 1;
    localparam logic [aw:0]   cnt_one = 1;

    logic [ew-1:0] mem0 [size];
    logic [ew-1:0] mem1 [size];

    logic [aw-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic [aw:0]   count0, count1;
    logic          full0, empty0, full1, empty1;
    logic          push0, xfer, pop1;
    logic [ew-1:0] entry_in, head0, head1;

`ifdef DUAL_FIFO_TLAST_EN
    assign entry_in   = {tlast_in0, data_in0};
    assign tlast_out1 = !empty1 && head1[data_width];
`else
    logic unused_tlast;
    assign unused_tlast = tlast_in0;
    assign entry_in     = data_in0;
    assign tlast_out1   = 1'b0;
`endif

    assign full0  = (count0 == depth);
    assign empty0 = (count0 == '0);
    assign full1  = (count1 == depth);
    assign empty1 = (count1 == '0);

    // Handshake rule: a beat moves on a rising edge only when its valid and ready are both high.
    // tready_out0 and tvalid_out1 depend on registered occupancy only.
    assign tready_out0 = !full0;
    assign tvalid_out1 = !empty1;
    assign push0       = tvalid_in0 && tready_out0;
    assign xfer        = !empty0 && !full1;
    assign pop1        = tvalid_out1 && tready_in1;

    assign head0     = mem0[rd_ptr0];
    assign head1     = mem1[rd_ptr1];
    assign data_out1 = empty1 ? '0 : head1[data_width-1:0];

    // Storage is never cleared; reset only invalidates it through the pointers.
    always_ff @(posedge clk) begin
        if (reset && push0) mem0[wr_ptr0] <= entry_in;
        if (reset && xfer)  mem1[wr_ptr1] <= head0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr0   <= '0;
            rd_ptr0   <= '0;
            count0    <= '0;
            wr_ptr1   <= '0;
            rd_ptr1   <= '0;
            count1    <= '0;
            data_out0 <= '0;
        end else begin
            if (push0) wr_ptr0 <= wr_ptr0 + ptr_one;
            if (xfer) begin
                rd_ptr0   <= rd_ptr0 + ptr_one;
                wr_ptr1   <= wr_ptr1 + ptr_one;
                data_out0 <= head0[data_width-1:0];
            end
            if (pop1) rd_ptr1 <= rd_ptr1 + ptr_one;

            case ({push0, xfer})
                2'b10:   count0 <= count0 + cnt_one;
                2'b01:   count0 <= count0 - cnt_one;
                default: count0 <= count0;
            endcase

            case ({xfer, pop1})
                2'b10:   count1 <= count1 + cnt_one;
                2'b01:   count1 <= count1 - cnt_one;
                default: count1 <= count1;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_fifo.sv
// Self-checking bench for dual_fifo: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based occupancy model.
module tb_dual_fifo;

    localparam int SIZE = 2048;
    localparam int DW   = 16;
`ifdef DUAL_FIFO_TLAST_EN
    localparam logic tl_en = 1'b1;
`else
    localparam logic tl_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in0;
    logic          tvalid_in0;
    logic          tlast_in0;
    logic          tready_out0;
    logic [DW-1:0] data_out0;
    logic [DW-1:0] data_out1;
    logic          tvalid_out1;
    logic          tlast_out1;
    logic          tready_in1;

    dual_fifo #(.data_width(DW), .size(SIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in0    (data_in0),
        .tvalid_in0  (tvalid_in0),
        .tlast_in0   (tlast_in0),
        .tready_out0 (tready_out0),
        .data_out0   (data_out0),
        .data_out1   (data_out1),
        .tvalid_out1 (tvalid_out1),
        .tlast_out1  (tlast_out1),
        .tready_in1  (tready_in1)
    );

    always #5 clk = ~clk;

    // Reference model: every stored word in order; the first n1 sit in the output stage.
    logic [DW:0]   exp_q[$];
    int            n1;
    logic [DW-1:0] m_dout0;

    int total = 0;
    int bad   = 0;
    int acc_cnt, out_cnt, tlast_cnt, tlast_idx, nready_cnt;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          r;
        logic          e_rdy;
        logic          e_val;
        logic [DW-1:0] e_d1;
        logic          e_l1;
        logic [DW-1:0] e_d0;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n0;
        n0 = exp_q.size() - n1;
        check("tready_out0", 32'(tready_out0), 32'(n0 < SIZE));
        check("tvalid_out1", 32'(tvalid_out1), 32'(n1 > 0));
        check("data_out1",   32'(data_out1),   (n1 > 0) ? 32'(exp_q[0][DW-1:0]) : 32'h0);
        check("tlast_out1",  32'(tlast_out1),  (n1 > 0) ? 32'(exp_q[0][DW]) : 32'h0);
        check("data_out0",   32'(data_out0),   32'(m_dout0));
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b0;
        tvalid_in0 = 1'b1;
        tready_in1 = 1'b1;
        data_in0   = 16'($urandom);
        tlast_in0  = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset      = 1'b1;
        tvalid_in0 = 1'b0;
        tready_in1 = 1'b0;
        exp_q.delete();
        n1      = 0;
        m_dout0 = '0;
        check("reset_tready_out0", 32'(tready_out0), 32'h1);
        check("reset_tvalid_out1", 32'(tvalid_out1), 32'h0);
        check("reset_data_out0",   32'(data_out0),   32'h0);
        check("reset_data_out1",   32'(data_out1),   32'h0);
        check("reset_tlast_out1",  32'(tlast_out1),  32'h0);
    endtask

    // One clock: drive inputs, log handshakes seen before the edge, advance model, compare.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        int  n0;
        logic m_push, m_xfer, m_pop;
        tvalid_in0 = v;
        data_in0   = d;
        tlast_in0  = l;
        tready_in1 = r;
        if (v && tready_out0) acc_cnt++;
        if (!tready_out0) nready_cnt++;
        if (tvalid_out1 && r) begin
            if (tlast_out1) begin
                tlast_cnt++;
                tlast_idx = out_cnt;
            end
            out_cnt++;
        end
        n0     = exp_q.size() - n1;
        m_push = v && (n0 < SIZE);
        m_xfer = (n0 > 0) && (n1 < SIZE);
        m_pop  = (n1 > 0) && r;
        @(posedge clk);
        #1;
        if (m_xfer) m_dout0 = exp_q[n1][DW-1:0];
        if (m_pop) begin
            void'(exp_q.pop_front());
            n1--;
        end
        if (m_xfer) n1++;
        if (m_push) exp_q.push_back({l & tl_en, d});
        check_model();
    endtask

    task automatic clear_counts();
        acc_cnt    = 0;
        out_cnt    = 0;
        tlast_cnt  = 0;
        tlast_idx  = -1;
        nready_cnt = 0;
    endtask

    initial begin
        reset      = 1'b0;
        tvalid_in0 = 1'b0;
        tready_in1 = 1'b0;
        tlast_in0  = 1'b0;
        data_in0   = '0;
        clear_counts();

        vecs[0] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,  16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, tl_en, 16'h1234};
        vecs[2] = '{1'b1, 16'habcd, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, tl_en, 16'h1234};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'habcd, 1'b0,  16'habcd};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  16'habcd};
        vecs[5] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  16'habcd};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555, tl_en, 16'h5555};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  16'h5555};

        do_reset(2);

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d_tready_out0", i), 32'(tready_out0), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_tvalid_out1", i), 32'(tvalid_out1), 32'(vecs[i].e_val));
            check($sformatf("vec%0d_data_out1", i),   32'(data_out1),   32'(vecs[i].e_d1));
            check($sformatf("vec%0d_tlast_out1", i),  32'(tlast_out1),  32'(vecs[i].e_l1));
            check($sformatf("vec%0d_data_out0", i),   32'(data_out0),   32'(vecs[i].e_d0));
        end

        // Streaming with the sink always ready.
        do_reset(1);
        clear_counts();
        for (int i = 0; i < 24000; i++) cycle(1'b1, 16'($urandom), i == 10, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1);
        check("stream_out_count",  32'(out_cnt),    32'd24000);
        check("stream_tlast_count", 32'(tlast_cnt), 32'(tl_en));
        check("stream_tlast_index", 32'(tlast_idx), tl_en ? 32'd10 : 32'hffffffff);
        check("stream_never_stall", 32'(nready_cnt), 32'd0);

        // Fill both stages with the sink stalled.
        do_reset(1);
        clear_counts();
        for (int i = 0; i < 2 * SIZE + 4; i++) cycle(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        check("fill_accepted", 32'(acc_cnt), 32'(2 * SIZE));
        check("fill_tready",   32'(tready_out0), 32'h0);
        check("fill_tvalid",   32'(tvalid_out1), 32'h1);

        // Single-cycle pop while full: slot propagates back to the slave port one cycle later.
        cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
        check("pulse_out_one",  32'(out_cnt), 32'd1);
        check("pulse_tready_0", 32'(tready_out0), 32'h0);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        check("pulse_tready_1", 32'(tready_out0), 32'h1);
        cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        check("pulse_accepted", 32'(acc_cnt), 32'(2 * SIZE + 1));
        check("pulse_refull",   32'(tready_out0), 32'h0);

        out_cnt = 0;
        for (int i = 0; i < 2 * SIZE + 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("drain_count", 32'(out_cnt), 32'(2 * SIZE));

        // Reset with 100 words in flight, then random traffic.
        do_reset(1);
        for (int i = 0; i < 100; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        do_reset(1);
        check("midreset_tvalid", 32'(tvalid_out1), 32'h0);
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_fifo.md
DUAL_FIFO -- requirements
Module: dual_fifo

Interface
REQ-001 The block SHALL have parameter data_width, default 16, giving the payload width in bits.
REQ-002 The block SHALL have parameter size, default 2048, giving the depth of each stage; it must be a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port data_in0, input, data_width bits: AXI-Stream slave payload.
REQ-006 The block SHALL have port tvalid_in0, input, 1 bit: slave valid.
REQ-007 The block SHALL have port tlast_in0, input, 1 bit: slave end-of-packet marker.
REQ-008 The block SHALL have port tready_out0, output, 1 bit: slave ready.
REQ-009 The block SHALL have port data_out0, output, data_width bits: monitor of the last word moved from stage 0 to stage 1.
REQ-010 The block SHALL have port data_out1, output, data_width bits: AXI-Stream master payload.
REQ-011 The block SHALL have port tvalid_out1, output, 1 bit: master valid.
REQ-012 The block SHALL have port tlast_out1, output, 1 bit: master end-of-packet marker.
REQ-013 The block SHALL have port tready_in1, input, 1 bit: master ready.

Function
REQ-014 The block SHALL contain two cascaded synchronous FIFOs: stage 0 is fed by the slave port, and stage 1 drives the master port; each stage holds size entries of {tlast, data}.
REQ-015 Each stage SHALL use binary read and write pointers of log2(size) bits that wrap modulo size, plus an occupancy count of log2(size)+1 bits; full when count==size, empty when count==0.
REQ-016 tready_out0 SHALL be !full0, derived combinationally from registered state only, with no dependence on tvalid_in0.
REQ-017 A slave write SHALL occur on an edge where tvalid_in0&&tready_out0, storing {tlast_in0,data_in0} at the stage-0 write pointer.
REQ-018 An internal transfer SHALL occur on an edge where !empty0&&!full1, popping the stage-0 head and pushing it into stage 1; at most one transfer per cycle.
REQ-019 data_out0 SHALL be a register loaded with the transferred data on every transfer edge and holding otherwise.
REQ-020 Stage 1 SHALL be show-ahead: tvalid_out1=!empty1, data_out1 is the stage-1 head data, and tlast_out1 is the head tlast; data_out1 and tlast_out1 are forced to 0 while empty1.
REQ-021 A master read SHALL occur on an edge where tvalid_out1&&tready_in1, advancing the stage-1 read pointer.
REQ-022 Latency SHALL be fixed: a word accepted at edge N is transferred at edge N+1 (if stage 1 is not full) and is presented on data_out1 after edge N+1.
REQ-023 A simultaneous push and pop in one stage SHALL leave its count unchanged, including when the stage is full; stage 0 may accept a slave write in the same cycle it is full only if a transfer pops it, but tready_out0 still reads 0 that cycle, so no write occurs.
REQ-024 Ordering SHALL be strict FIFO; no word is dropped or duplicated, and total capacity is 2*size words.
REQ-025 tvalid_out1, data_out1 and tlast_out1 SHALL remain stable while tready_in1=0.

Reset
REQ-026 When reset=0 at a rising edge, all pointers and counts SHALL be cleared and data_out0 set to 0, giving tready_out0=1, tvalid_out1=0, data_out1=0 and tlast_out1=0 after that edge.
REQ-027 Reset asserted mid-operation SHALL discard all stored words, and no handshake SHALL complete on the reset edge; memory contents are not cleared.

Configuration
REQ-028 With macro DUAL_FIFO_TLAST_EN defined, tlast SHALL be stored and propagated as specified above.
REQ-029 Without DUAL_FIFO_TLAST_EN, entries SHALL store data only, tlast_in0 SHALL be ignored, and tlast_out1 SHALL be tied to 0.

Verification
REQ-030 The bench SHALL cover reset: reset=0 for 2 cycles -> tready_out0=1, tvalid_out1=0, data_out0=0, data_out1=0.
REQ-031 The bench SHALL cover a single word: 16'h1234 with tlast=1 accepted at edge N -> after edge N+1, data_out1=16'h1234, tlast_out1=1, data_out0=16'h1234.
REQ-032 The bench SHALL cover streaming: 24000 words with tlast on index 10 and tready_in1=1 -> identical output order, tlast_out1 only on the 11th word, and tready_out0 never 0.
REQ-033 The bench SHALL cover fill: tready_in1=0 while pushing -> exactly 4096 words accepted, then tready_out0=0; setting tready_in1=1 drains 4096 words in order.
REQ-034 The bench SHALL cover full with simultaneous pop: both stages full and tready_in1 pulsed for 1 cycle -> one word out, tready_out0=1 two cycles later, and one new word accepted.
REQ-035 The bench SHALL cover reset mid-stream: reset=0 with 100 words stored -> the next cycle shows tvalid_out1=0, and subsequent words emerge without stale data.
